muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It is the first multi-cycle execution block of the CPU and adds MULT, MULTU, DIV, DIVU, MFHI/MFLO and MTHI/MTLO support to the 31-instruction single-cycle datapath. The controller launches an operation with `start`, stalls the PC and register-file write path while `busy` is high, and reads results from `hi`/`lo`. The operand width is a parameter, so the same block serves a later 64-bit datapath.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_unit.sv | 109 ++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and op decode helpers shared by the unit and the controller
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: controller <-> multiply/divide unit handshake and HI/LO access
interface muldiv_if #(parameter int WIDTH = 32);

    logic              start;
    muldiv_pkg::op_e   op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  wdata;
    logic              cancel;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, cancel,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(parameter int WIDTH = 32) (
    input  logic             mul,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // multiply shifts the partial product right into lo; divide shifts the dividend left into the remainder
    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, d} : '0);
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        hi_out  = mul ? sum[WIDTH:1] : (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]);
        lo_out  = mul ? {sum[0], lo_in[WIDTH-1:1]} : {lo_in[WIDTH-2:0], ~diff[WIDTH]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = 32) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    state_e            state;
    logic              div_r;
    logic              bzero;
    logic              neg_res;
    logic              neg_rem;
    logic [WIDTH-1:0]  dsr;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;
    logic              sgn;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mul    (~div_r),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .d      (dsr),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // operand magnitudes for launch and sign-corrected results for write-back; the divide-by-zero
    // remainder comes out as |a| and its dividend-sign fix-up restores a, so only lo needs forcing
    always_comb begin
        sgn   = op_is_signed(bus.op);
        abs_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        prod  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo   = bzero ? '1 : (neg_res ? -acc_lo : acc_lo);
        rem   = neg_rem ? -acc_hi : acc_hi;
    end

    // IDLE -> CALC (WIDTH steps) -> FIX (write HI/LO, pulse done) -> IDLE; cancel aborts from CALC/FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            div_r    <= 1'b0;
            bzero    <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dsr      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.hi_we) bus.hi <= bus.wdata;
                    if (bus.lo_we) bus.lo <= bus.wdata;
                    if (bus.start) begin
                        div_r    <= op_is_div(bus.op);
                        bzero    <= bus.b == '0;
                        neg_res  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem  <= sgn & bus.a[WIDTH-1];
                        dsr      <= op_is_div(bus.op) ? abs_b : abs_a;
                        acc_lo   <= op_is_div(bus.op) ? abs_a : abs_b;
                        acc_hi   <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        bus.busy <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + WIDTH'(1);
                        if (cnt == WIDTH'(WIDTH - 1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                    if (!bus.cancel) begin
                        bus.done <= 1'b1;
                        bus.hi   <= div_r ? rem : prod[2*WIDTH-1:WIDTH];
                        bus.lo   <= div_r ? quo : prod[WIDTH-1:0];
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, latency-level reference model and per-cycle output comparison
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    int           rem_cyc = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
        logic [63:0] p;
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = '0;
        case (o)
            OP_MULT:  begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
            OP_MULTU: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
            OP_DIV:   if (y == '0) begin h = x; l = '1; end
                      else begin h = W'(sx % sy); l = W'(sx / sy); end
            default:  if (y == '0) begin h = x; l = '1; end
                      else begin h = x % y; l = x / y; end
        endcase
    endfunction

    // reference: a result appears W+1 edges after the accepted start unless cancelled
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; rem_cyc = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (bus.cancel) m_busy = 1'b0;
                else if (rem_cyc == 1) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                end else rem_cyc--;
            end else begin
                if (bus.hi_we) m_hi = bus.wdata;
                if (bus.lo_we) m_lo = bus.wdata;
                if (bus.start) begin
                    ref_op(bus.op, bus.a, bus.b, p_hi, p_lo);
                    rem_cyc = W + 1;
                    m_busy  = 1'b1;
                end
            end
        end
    end

    // every cycle the DUT outputs must equal the reference
    always @(negedge clk) begin
        chk("busy", {31'b0, bus.busy}, {31'b0, m_busy});
        chk("done", {31'b0, bus.done}, {31'b0, m_done});
        chk("hi", bus.hi, m_hi);
        chk("lo", bus.lo, m_lo);
    end

    task automatic launch(input op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = op_e'($urandom_range(0, 3));
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!bus.done && lat < 100) begin
            bc += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        chk("done timeout", {31'b0, bus.done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bc;
        logic saw;
        bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.cancel = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'b0, bus.busy}, 32'd0);
        chk("rst done", {31'b0, bus.done}, 32'd0);
        chk("rst hi", bus.hi, 32'd0);
        chk("rst lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(lat, bc);
        chk("mult latency", lat, 32'd33);
        chk("mult busy cycles", bc, 32'd33);
        chk("mult hi", bus.hi, 32'hFFFFFFFF);
        chk("mult lo", bus.lo, 32'hFFFFFFF1);

        launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc);
        chk("multu hi", bus.hi, 32'hFFFFFFFE);
        chk("multu lo", bus.lo, 32'h00000001);

        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bc);
        chk("div lo", bus.lo, 32'hFFFFFFFD);
        chk("div hi", bus.hi, 32'hFFFFFFFF);

        launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bc);
        chk("div ovf lo", bus.lo, 32'h80000000);
        chk("div ovf hi", bus.hi, 32'h00000000);

        launch(OP_DIVU, 32'd7, 32'd0);
        wait_done(lat, bc);
        chk("divu0 latency", lat, 32'd33);
        chk("divu0 lo", bus.lo, 32'hFFFFFFFF);
        chk("divu0 hi", bus.hi, 32'd7);

        launch(OP_DIV, 32'hFFFFFFFB, 32'd0);
        wait_done(lat, bc);
        chk("div0 lo", bus.lo, 32'hFFFFFFFF);
        chk("div0 hi", bus.hi, 32'hFFFFFFFB);

        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd3; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        wait_done(lat, bc);
        chk("divu lo", bus.lo, 32'd14);
        chk("divu hi", bus.hi, 32'd2);

        launch(OP_MULTU, 32'd6, 32'd7);
        chk("b2b accepted", {31'b0, bus.busy}, 32'd1);
        wait_done(lat, bc);
        chk("b2b latency", lat, 32'd33);
        chk("b2b lo", bus.lo, 32'd42);
        chk("b2b hi", bus.hi, 32'd0);

        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo", bus.lo, 32'h1234);

        launch(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        chk("cancel busy", {31'b0, bus.busy}, 32'd0);
        chk("cancel lo", bus.lo, 32'h1234);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw |= bus.done;
        end
        chk("cancel no done", {31'b0, saw}, 32'd0);

        launch(OP_MULT, 32'd5, 32'd5);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", {31'b0, bus.busy}, 32'd0);
        chk("arst done", {31'b0, bus.done}, 32'd0);
        chk("arst hi", bus.hi, 32'd0);
        chk("arst lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        launch(OP_MULTU, 32'd3, 32'd4);
        wait_done(lat, bc);
        chk("post rst lo", bus.lo, 32'd12);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
